// File: rtl/viterbi_decoder_k3_if.sv
// Symbol-in / decoded-bit-out bundle between the channel deserializer and the K=3 Viterbi decoder.
// There is no backpressure: the master presents one code symbol per code_valid cycle.
interface viterbi_decoder_k3_if;
  logic       code_valid;
  logic [1:0] code_in;
  logic       data_valid;
  logic       data_out;
  logic       sym_cnt_full;

  modport master (
    output code_valid, code_in,
    input  data_valid, data_out, sym_cnt_full
  );

  modport slave (
    input  code_valid, code_in,
    output data_valid, data_out, sym_cnt_full
  );
endinterface

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision register-exchange Viterbi decoder, rate 1/2, K=3 (g0=111, g1=101).
// One decoded bit per accepted symbol, TB_DEPTH symbols behind the input; no backpressure.
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 15,
  parameter int METRIC_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  viterbi_decoder_k3_if.slave  bus
);

  localparam int L     = TB_DEPTH;
  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TB_DEPTH - 1);

  // Survivor registers keep only L-1 bits: the oldest bit of a path is
  // consumed on the same step it is formed, so it never needs storing.
  logic [L-2:0]      sv_q [4];
  logic [L-2:0]      sv_d [4];
  logic [METRIC_W-1:0] pm_q [4];
  logic [METRIC_W-1:0] pm_d [4];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              vld_q, vld_d;
  logic              dout_q, dout_d;

  logic [METRIC_W:0] c0 [4];
  logic [METRIC_W:0] c1 [4];
  logic [METRIC_W:0] acc [4];
  logic              take1 [4];
  logic [L-1:0]      surv [4];
  logic [METRIC_W:0] min_m;
  logic [1:0]        best;

  function automatic logic [1:0] bm(input logic [1:0] pred, input logic d, input logic [1:0] sym);
    logic [1:0] expct;
    expct = {d ^ pred[1], d ^ pred[0] ^ pred[1]};
    return {1'b0, sym[0] ^ expct[0]} + {1'b0, sym[1] ^ expct[1]};
  endfunction

  always_comb begin
    // New state {a,d} is reached from {0,a} or {1,a}; ties keep the s1=0 predecessor.
    for (int n = 0; n < 4; n++) begin
      c0[n]    = {1'b0, pm_q[n/2]}
               + {{(METRIC_W-1){1'b0}}, bm(2'(n/2), 1'(n%2), bus.code_in)};
      c1[n]    = {1'b0, pm_q[2+n/2]}
               + {{(METRIC_W-1){1'b0}}, bm(2'(2+n/2), 1'(n%2), bus.code_in)};
      take1[n] = c1[n] < c0[n];
      acc[n]   = take1[n] ? c1[n] : c0[n];
      surv[n]  = {take1[n] ? sv_q[2+n/2] : sv_q[n/2], 1'(n%2)};
    end

    min_m = acc[0];
    best  = 2'd0;
    for (int n = 1; n < 4; n++) begin
      if (acc[n] < min_m) begin
        min_m = acc[n];
        best  = 2'(n);
      end
    end

    pm_d   = pm_q;
    sv_d   = sv_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    vld_d  = 1'b0;
    dout_d = dout_q;

    if (bus.code_valid) begin
      for (int n = 0; n < 4; n++) begin
        pm_d[n] = METRIC_W'(acc[n] - min_m);
        sv_d[n] = surv[n][L-2:0];
      end
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        vld_d  = 1'b1;
        full_d = 1'b1;
        dout_d = surv[best][L-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= (i == 0) ? '0 : METRIC_W'(4);
        sv_q[i] <= '0;
      end
      cnt_q  <= '0;
      full_q <= 1'b0;
      vld_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      pm_q   <= pm_d;
      sv_q   <= sv_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  assign bus.data_valid   = vld_q;
  assign bus.data_out     = dout_q;
  assign bus.sym_cnt_full = full_q;

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Directed bench for viterbi_decoder_k3: known vector, clean/corrupted/gapped random streams,
// all-zero stream and mid-stream reset, against a reference encoder and expected-bit queue.
module tb_viterbi_decoder_k3;
  localparam int L = 15;
  localparam int N = 200;

  logic clk;
  logic reset;
  viterbi_decoder_k3_if bus();

  viterbi_decoder_k3 #(.TB_DEPTH(L), .METRIC_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   acc;
  int   strobes;
  bit   last_bit;
  bit   exp_q[$];
  logic [1:0] enc_s;
  bit   data_a [N];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Reset asserted away from any clock edge; outputs must clear without a clock.
  task automatic do_reset();
    bus.code_valid = 1'b0;
    bus.code_in    = 2'b00;
    @(posedge clk);
    #4 reset = 1'b1;
    #1;
    check("rst_valid", bus.data_valid, 0);
    check("rst_out",   bus.data_out, 0);
    check("rst_full",  bus.sym_cnt_full, 0);
    check("rst_pm0",   dut.pm_q[0], 0);
    check("rst_pm1",   dut.pm_q[1], 4);
    check("rst_pm2",   dut.pm_q[2], 4);
    check("rst_pm3",   dut.pm_q[3], 4);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    acc      = 0;
    strobes  = 0;
    last_bit = 1'b0;
    enc_s    = 2'b00;
  endtask

  task automatic send(input logic [1:0] code, input bit d, input bit v);
    bit exp_vld;
    bus.code_valid = v;
    bus.code_in    = code;
    if (v) exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (v) acc++;
    exp_vld = v && (acc >= L);
    check("valid", bus.data_valid, exp_vld);
    check("full",  bus.sym_cnt_full, acc >= L);
    if (exp_vld) begin
      last_bit = exp_q[acc-L];
      strobes++;
      check("data", bus.data_out, last_bit);
    end else begin
      check("hold", bus.data_out, last_bit);
    end
  endtask

  task automatic enc_send(input bit d, input logic [1:0] flip);
    logic [1:0] code;
    code  = {d ^ enc_s[1], d ^ enc_s[0] ^ enc_s[1]} ^ flip;
    enc_s = {enc_s[0], d};
    send(code, d, 1'b1);
  endtask

  // Data 1,0,1,1 then zeros; codes worked out by hand from state 0.
  task automatic known_vector();
    logic [1:0] kv_code [6];
    bit         kv_bit  [6];
    kv_code = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    kv_bit  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) send(kv_code[i], kv_bit[i], 1'b1);
    for (int i = 6; i < 2*L; i++) send(2'b00, 1'b0, 1'b1);
    check("kv_strobes", 16'(strobes), 16'(2*L - L + 1));
  endtask

  initial begin
    reset          = 1'b0;
    bus.code_valid = 1'b0;
    bus.code_in    = 2'b00;
    for (int i = 0; i < N; i++) data_a[i] = 1'($urandom_range(0, 1));

    do_reset();
    known_vector();

    do_reset();
    for (int i = 0; i < N; i++) enc_send(data_a[i], 2'b00);
    check("clean_strobes", 16'(strobes), 16'(N - L + 1));

    // One flipped code bit every 12th symbol, alternating g0/g1.
    do_reset();
    for (int i = 0; i < N; i++)
      enc_send(data_a[i], (i % 12 == 11) ? (((i / 12) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
    check("corr_strobes", 16'(strobes), 16'(N - L + 1));

    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++)
        send(2'($urandom_range(0, 3)), 1'b0, 1'b0);
      enc_send(data_a[i], 2'b00);
    end
    check("gap_strobes", 16'(strobes), 16'(N - L + 1));

    do_reset();
    for (int i = 0; i < 50; i++) begin
      send(2'b00, 1'b0, 1'b1);
      check("zero_pm0", dut.pm_q[0], 0);
    end
    check("zero_strobes", 16'(strobes), 16'(50 - L + 1));

    do_reset();
    for (int i = 0; i < 30; i++) enc_send(data_a[i], 2'b00);
    do_reset();
    known_vector();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
